// File: rtl/parity_frame_checker_if.sv
// Serial-line bundle for parity_frame_checker: bit strobe in, recovered word and status out.
interface parity_frame_checker_if #(
    parameter int DATA_W = 3
);
    logic              w;
    logic              w_valid;
    logic [DATA_W-1:0] data_out;
    logic              done;
    logic              par_err;
    logic              frm_err;
    logic              busy;

    modport master (
        output w, w_valid,
        input  data_out, done, par_err, frm_err, busy
    );

    modport slave (
        input  w, w_valid,
        output data_out, done, par_err, frm_err, busy
    );
endinterface

// File: rtl/parity_frame_checker.sv
// Even-parity serial frame receiver: start, DATA_W data bits LSB first, parity, stop.
// Optional ERR_COUNT_EN adds a saturating bad-frame counter output err_cnt.
module parity_frame_checker #(
    parameter int DATA_W = 3
`ifdef ERR_COUNT_EN
    ,
    parameter int CNT_W  = 8
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    parity_frame_checker_if.slave   bus
`ifdef ERR_COUNT_EN
    ,
    output logic [CNT_W-1:0]        err_cnt
`endif
);
    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t            state, state_next;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] sr;
    logic              run_par;
    logic              par_bad;
    logic [DATA_W-1:0] data_q;
    logic              done_q;
    logic              par_err_q;
    logic              frm_err_q;
    logic              frame_end;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        frame_end  = 1'b0;
        if (bus.w_valid) begin
            unique case (state)
                IDLE:   if (!bus.w) state_next = DATA;
                DATA:   if (cnt == LAST) state_next = PARITY;
                PARITY: state_next = STOP;
                STOP: begin
                    state_next = IDLE;
                    frame_end  = 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            sr        <= '0;
            run_par   <= 1'b0;
            par_bad   <= 1'b0;
            data_q    <= '0;
            done_q    <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.w_valid) begin
                unique case (state)
                    IDLE: if (!bus.w) begin
                        cnt     <= '0;
                        run_par <= 1'b0;
                    end
                    DATA: begin
                        sr[cnt] <= bus.w;
                        run_par <= run_par ^ bus.w;
                        if (cnt != LAST) cnt <= cnt + CW'(1);
                    end
                    PARITY: par_bad <= run_par ^ bus.w;
                    STOP: begin
                        data_q    <= sr;
                        par_err_q <= par_bad;
                        frm_err_q <= ~bus.w;
                        done_q    <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef ERR_COUNT_EN
    // Counts at the stop-bit edge so the new value appears together with done.
    always_ff @(posedge clk) begin
        if (rst)
            err_cnt <= '0;
        else if (frame_end && (par_bad || !bus.w) && (err_cnt != '1))
            err_cnt <= err_cnt + CNT_W'(1);
    end
`endif

    assign bus.data_out = data_q;
    assign bus.done     = done_q;
    assign bus.par_err  = par_err_q;
    assign bus.frm_err  = frm_err_q;
    assign bus.busy     = (state != IDLE);
endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed bench for parity_frame_checker; expected frames go through a scoreboard queue.
module tb_parity_frame_checker;
    localparam int DW = 3;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          par_err;
        logic          frm_err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;
    int   done_cnt = 0;
    logic prev_done = 1'b0;

    always #5 clk = ~clk;

    parity_frame_checker_if #(.DATA_W(DW)) bus ();

`ifdef ERR_COUNT_EN
    logic [1:0] err_cnt;
    parity_frame_checker #(.DATA_W(DW), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .bus(bus), .err_cnt(err_cnt));
`else
    parity_frame_checker #(.DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .bus(bus));
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: one pop per done pulse, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            exp_t e;
            done_cnt++;
            check("done_width", {31'd0, prev_done}, 32'd0);
            check("sb_nonempty", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("data_out", {29'd0, bus.data_out}, {29'd0, e.data});
                check("par_err", {31'd0, bus.par_err}, {31'd0, e.par_err});
                check("frm_err", {31'd0, bus.frm_err}, {31'd0, e.frm_err});
            end
        end
        prev_done = bus.done;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        bus.w_valid = 1'b0;
        bus.w = 1'b1;
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    task automatic send_bit(input logic b, input int unsigned gap);
        bus.w = b;
        bus.w_valid = 1'b1;
        step();
        for (int unsigned i = 0; i < gap; i++) begin
            bus.w_valid = 1'b0;
            bus.w = ~bus.w;
            step();
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic s,
                              input int unsigned gap);
        exp_t e;
        e.data = d;
        e.par_err = (^d) ^ p;
        e.frm_err = ~s;
        sb.push_back(e);
        send_bit(1'b0, gap);
        for (int unsigned i = 0; i < DW; i++) send_bit(d[i], gap);
        send_bit(p, gap);
        send_bit(s, gap);
        bus.w_valid = 1'b0;
        bus.w = 1'b1;
    endtask

    initial begin
        int exp_done = 0;
        bus.w = 1'b1;
        bus.w_valid = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_data", {29'd0, bus.data_out}, 32'd0);
        check("rst_perr", {31'd0, bus.par_err}, 32'd0);
        check("rst_ferr", {31'd0, bus.frm_err}, 32'd0);

        // Test 1: good frame, data 101
        send_bit(1'b0, 0);
        check("busy_mid", {31'd0, bus.busy}, 32'd1);
        bus.w_valid = 1'b0;
        step();
        check("hold_busy", {31'd0, bus.busy}, 32'd1);
        sb.push_back('{data: 3'b101, par_err: 1'b0, frm_err: 1'b0});
        send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0);
        send_bit(1'b0, 0); send_bit(1'b1, 0);
        bus.w_valid = 1'b0;
        check("t1_done_now", {31'd0, bus.done}, 32'd1);
        idle(1);
        exp_done++;
        check("t1_busy_after", {31'd0, bus.busy}, 32'd0);
        check("t1_done_cnt", done_cnt, exp_done);

        // Test 2: parity error
        send_frame(3'b011, 1'b1, 1'b1, 0);
        idle(1);
        exp_done++;
        check("t2_done_cnt", done_cnt, exp_done);

        // Test 3: framing error, then idle ones must not start a frame
        send_frame(3'b111, 1'b1, 1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        check("t3_busy_idle", {31'd0, bus.busy}, 32'd0);
        idle(2);
        exp_done++;
        check("t3_done_cnt", done_cnt, exp_done);
        check("t3_frm_hold", {31'd0, bus.frm_err}, 32'd1);

        // Test 4: test-1 frame with invalid gaps and toggling line
        send_frame(3'b101, 1'b0, 1'b1, 2);
        idle(3);
        exp_done++;
        check("t4_done_cnt", done_cnt, exp_done);

        // Test 5: reset mid-frame aborts, then good frame
        send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b1, 0);
        bus.w_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_busy", {31'd0, bus.busy}, 32'd0);
        check("t5_data_rst", {29'd0, bus.data_out}, 32'd0);
        idle(2);
        check("t5_no_done", done_cnt, exp_done);
        send_frame(3'b010, 1'b1, 1'b1, 0);
        idle(1);
        exp_done++;
        check("t5_done_cnt", done_cnt, exp_done);

`ifdef ERR_COUNT_EN
        begin
            logic [1:0] cnt_model = 2'd0;
            check("t6_cnt_start", {30'd0, err_cnt}, 32'd0);
            for (int i = 0; i < 5; i++) begin
                send_frame(3'b001, 1'b0, 1'b1, 0);
                idle(1);
                exp_done++;
                if (cnt_model != 2'd3) cnt_model = cnt_model + 2'd1;
                check("t6_cnt_bad", {30'd0, err_cnt}, {30'd0, cnt_model});
            end
            send_frame(3'b110, 1'b0, 1'b1, 0);
            idle(1);
            exp_done++;
            check("t6_cnt_good", {30'd0, err_cnt}, 32'd3);
            rst = 1'b1;
            step();
            rst = 1'b0;
            check("t6_cnt_rst", {30'd0, err_cnt}, 32'd0);
            check("t6_done_cnt", done_cnt, exp_done);
        end
`endif

        check("sb_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
